ad9767_seg_sequencer: RTL and testbench

Two-channel segment sequencer for the AN9767 / AD9767 dual 14-bit DAC. It sits between a command source (control FSM or soft CPU) and the `da1_data` / `da2_data` buses, which run on the 125 MHz DAC clock. Per channel, it queues waveform segments (start code, signed step, sample count, hold divider) and plays them back-to-back. Ramp arithmetic saturates to the DAC code range, and idle or aborted channels park at midscale (0 V).

---
 rtl/ad9767_pkg.sv | 20 ++
 rtl/ad9767_seg_engine.sv | 174 +++++++++++++++++
 rtl/ad9767_seg_sequencer.sv | 68 ++++++
 tb/tb_ad9767_seg_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad9767_pkg.sv
// Shared constants and types for the AD9767 two-channel segment sequencer.
package ad9767_pkg;

    localparam logic [13:0] DA_MID = 14'h2000;
    localparam logic [13:0] DA_MAX = 14'h3FFF;

    // Segment record at the default field widths (14-bit codes, 16-bit length, 8-bit divider).
    typedef struct packed {
        logic [13:0] start;
        logic [13:0] step;
        logic [15:0] len;
        logic [7:0]  div;
    } seg_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ch_state_e;

endpackage

// File: rtl/ad9767_seg_engine.sv
// One DAC channel: DEPTH-entry segment queue, playback FSM, ramp accumulator and saturator.
module ad9767_seg_engine
    import ad9767_pkg::*;
#(
    parameter int DATA_W = 14,
    parameter int DEPTH  = 4,
    parameter int LEN_W  = 16,
    parameter int DIV_W  = 8,
    parameter int LVL_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              abort,
    input  logic              push,
    input  logic [DATA_W-1:0] push_start,
    input  logic [DATA_W-1:0] push_step,
    input  logic [LEN_W-1:0]  push_len,
    input  logic [DIV_W-1:0]  push_div,
    output logic              full,
    output logic [LVL_W-1:0]  level,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              seg_done,
    output logic              sat
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};

    typedef struct packed {
        logic [DATA_W-1:0] start;
        logic [DATA_W-1:0] step;
        logic [LEN_W-1:0]  len;
        logic [DIV_W-1:0]  div;
    } rec_t;

    rec_t mem_q [DEPTH];

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  count_q, count_d;
    ch_state_e         state_q, state_d;
    logic [DATA_W-1:0] cur_q, cur_d, step_q, step_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [DIV_W-1:0]  hold_q, hold_d, div_q, div_d;
    logic              seg_done_q, seg_done_d, sat_q, sat_d;

    logic              pop;
    rec_t              head;
    logic [DATA_W+1:0] sum;
    logic [DATA_W-1:0] sum_clamped;
    logic              sum_clip;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {push_start, push_step, push_len, push_div};
        end
    end

    assign head = mem_q[rd_ptr_q];

    // Zero-extended code plus sign-extended step; the two guard bits flag under/overflow.
    always_comb begin
        sum         = {2'b00, cur_q} + {{2{step_q[DATA_W-1]}}, step_q};
        sum_clamped = sum[DATA_W-1:0];
        sum_clip    = 1'b0;
        if (sum[DATA_W+1]) begin
            sum_clamped = '0;
            sum_clip    = 1'b1;
        end else if (sum[DATA_W]) begin
            sum_clamped = '1;
            sum_clip    = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        step_d  = step_q;
        rem_d   = rem_q;
        hold_d  = hold_q;
        div_d   = div_q;
        sat_d   = 1'b0;
        pop     = 1'b0;

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop = 1'b1;
                end
            end
            RUN: begin
                if (hold_q == '0) begin
                    if (rem_q == LEN_W'(1)) begin
                        if (count_q != '0) begin
                            pop = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cur_d  = sum_clamped;
                        sat_d  = sum_clip;
                        rem_d  = rem_q - LEN_W'(1);
                        hold_d = div_q;
                    end
                end else begin
                    hold_d = hold_q - DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            state_d = RUN;
            cur_d   = head.start;
            step_d  = head.step;
            rem_d   = (head.len == '0) ? LEN_W'(1) : head.len;
            hold_d  = head.div;
            div_d   = head.div;
        end

        // Registered pulse: flag the cycle that will show the segment's final clock.
        seg_done_d = (state_d == RUN) && (hold_d == '0) && (rem_d == LEN_W'(1));

        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + LVL_W'(push) - LVL_W'(pop);

        if (abort) begin
            state_d    = IDLE;
            cur_d      = MID;
            seg_done_d = 1'b0;
            sat_d      = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= IDLE;
            cur_q      <= MID;
            step_q     <= '0;
            rem_q      <= '0;
            hold_q     <= '0;
            div_q      <= '0;
            seg_done_q <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            cur_q      <= cur_d;
            step_q     <= step_d;
            rem_q      <= rem_d;
            hold_q     <= hold_d;
            div_q      <= div_d;
            seg_done_q <= seg_done_d;
            sat_q      <= sat_d;
        end
    end

    assign full     = (count_q == LVL_W'(DEPTH));
    assign level    = count_q;
    assign data     = cur_q;
    assign busy     = (state_q == RUN);
    assign seg_done = seg_done_q;
    assign sat      = sat_q;

endmodule

// File: rtl/ad9767_seg_sequencer.sv
// Top level: routes segment commands to the two channel engines and packs their outputs.
module ad9767_seg_sequencer
    import ad9767_pkg::*;
#(
    parameter int DATA_W = 14,
    parameter int DEPTH  = 4,
    parameter int LEN_W  = 16,
    parameter int DIV_W  = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic                             cmd_ch,
    input  logic [DATA_W-1:0]                cmd_start,
    input  logic [DATA_W-1:0]                cmd_step,
    input  logic [LEN_W-1:0]                 cmd_len,
    input  logic [DIV_W-1:0]                 cmd_div,
    input  logic                             abort,
    output logic [DATA_W-1:0]                da1_data,
    output logic [DATA_W-1:0]                da2_data,
    output logic [1:0]                       ch_busy,
    output logic [1:0]                       seg_done,
    output logic [1:0]                       sat,
    output logic [2*$clog2(DEPTH+1)-1:0]     q_level
);

    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [1:0]        full_w;
    logic [1:0]        push_w;
    logic [DATA_W-1:0] data_w [2];

    assign cmd_ready = !full_w[cmd_ch] && !abort;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ch
            assign push_w[gi] = cmd_valid && cmd_ready && (cmd_ch == 1'(gi));

            ad9767_seg_engine #(
                .DATA_W (DATA_W),
                .DEPTH  (DEPTH),
                .LEN_W  (LEN_W),
                .DIV_W  (DIV_W),
                .LVL_W  (LVL_W)
            ) u_engine (
                .clk        (clk),
                .rst_n      (rst_n),
                .abort      (abort),
                .push       (push_w[gi]),
                .push_start (cmd_start),
                .push_step  (cmd_step),
                .push_len   (cmd_len),
                .push_div   (cmd_div),
                .full       (full_w[gi]),
                .level      (q_level[gi*LVL_W +: LVL_W]),
                .data       (data_w[gi]),
                .busy       (ch_busy[gi]),
                .seg_done   (seg_done[gi]),
                .sat        (sat[gi])
            );
        end
    endgenerate

    assign da1_data = data_w[0];
    assign da2_data = data_w[1];

endmodule

// File: tb/tb_ad9767_seg_sequencer.sv
// Scoreboard bench: accepted commands expand into per-clock expected samples; a monitor checks every cycle.
module tb_ad9767_seg_sequencer;

    localparam int DATA_W = 14;
    localparam int DEPTH  = 4;
    localparam int LEN_W  = 16;
    localparam int DIV_W  = 8;
    localparam int LW     = $clog2(DEPTH + 1);
    localparam int MIDV   = 'h2000;
    localparam int MAXV   = 'h3FFF;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_ch;
    logic [DATA_W-1:0] cmd_start;
    logic [DATA_W-1:0] cmd_step;
    logic [LEN_W-1:0]  cmd_len;
    logic [DIV_W-1:0]  cmd_div;
    logic              abort;
    logic [DATA_W-1:0] da1_data, da2_data;
    logic [1:0]        ch_busy, seg_done, sat;
    logic [2*LW-1:0]   q_level;

    ad9767_seg_sequencer #(
        .DATA_W (DATA_W), .DEPTH (DEPTH), .LEN_W (LEN_W), .DIV_W (DIV_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_ch    (cmd_ch),
        .cmd_start (cmd_start),
        .cmd_step  (cmd_step),
        .cmd_len   (cmd_len),
        .cmd_div   (cmd_div),
        .abort     (abort),
        .da1_data  (da1_data),
        .da2_data  (da2_data),
        .ch_busy   (ch_busy),
        .seg_done  (seg_done),
        .sat       (sat),
        .q_level   (q_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        bit done;
        bit sat;
        bit first;
        int min_edge;
    } exp_t;

    exp_t expq [2][$];
    int   pending [2];
    int   last_val [2];
    int   cyc = 0;
    int   abort_edge = -1;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input int ch, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s ch%0d cyc %0d: got 0x%0h expected 0x%0h", nm, ch, cyc, act, exp);
        end
    endtask

    // Reference: expand a segment into its clock-by-clock output from the arithmetic rules.
    task automatic model_push(input int ch, input int st, input int sp, input int ln, input int dv);
        int   n;
        int   v;
        int   nxt;
        bit   clipped;
        exp_t e;
        n       = (ln == 0) ? 1 : ln;
        v       = st;
        clipped = 1'b0;
        for (int k = 0; k < n; k++) begin
            for (int h = 0; h <= dv; h++) begin
                e.data     = v;
                e.done     = (k == n - 1) && (h == dv);
                e.sat      = (h == 0) && clipped;
                e.first    = (k == 0) && (h == 0);
                e.min_edge = e.first ? cyc + 2 : 0;
                expq[ch].push_back(e);
            end
            nxt     = v + sp;
            clipped = (nxt < 0) || (nxt > MAXV);
            v       = (nxt < 0) ? 0 : ((nxt > MAXV) ? MAXV : nxt);
        end
        pending[ch]++;
    endtask

    // Monitor: one comparison set per channel per clock.
    always begin
        @(posedge clk);
        #1;
        cyc++;
        for (int ch = 0; ch < 2; ch++) begin
            int   dv;
            exp_t e;
            dv = (ch == 0) ? int'(da1_data) : int'(da2_data);
            if (!rst_n || abort_edge == cyc) begin
                expq[ch].delete();
                pending[ch]  = 0;
                last_val[ch] = MIDV;
                chk("flush_data", ch, dv, MIDV);
                chk("flush_busy", ch, int'(ch_busy[ch]), 0);
                chk("flush_done", ch, int'(seg_done[ch]), 0);
                chk("flush_sat", ch, int'(sat[ch]), 0);
            end else if (expq[ch].size() > 0 && expq[ch][0].min_edge <= cyc) begin
                e = expq[ch].pop_front();
                if (e.first) pending[ch]--;
                chk("data", ch, dv, e.data);
                chk("busy", ch, int'(ch_busy[ch]), 1);
                chk("seg_done", ch, int'(seg_done[ch]), int'(e.done));
                chk("sat", ch, int'(sat[ch]), int'(e.sat));
                last_val[ch] = e.data;
            end else begin
                chk("idle_data", ch, dv, last_val[ch]);
                chk("idle_busy", ch, int'(ch_busy[ch]), 0);
                chk("idle_done", ch, int'(seg_done[ch]), 0);
                chk("idle_sat", ch, int'(sat[ch]), 0);
            end
            chk("q_level", ch, int'(q_level[ch*LW +: LW]), pending[ch]);
        end
    end

    // Called at a falling edge; returns at a falling edge with cmd_valid dropped.
    task automatic send(input int ch, input int st, input int sp, input int ln, input int dv);
        int waited = 0;
        cmd_valid = 1'b1;
        cmd_ch    = 1'(ch);
        cmd_start = DATA_W'(st);
        cmd_step  = DATA_W'(sp);
        cmd_len   = LEN_W'(ln);
        cmd_div   = DIV_W'(dv);
        forever begin
            #1;
            chk("cmd_ready", ch, int'(cmd_ready), int'(pending[ch] < DEPTH));
            if (cmd_ready) begin
                model_push(ch, st, sp, ln, dv);
                break;
            end
            waited++;
            if (waited > 5000) begin
                checks++;
                errors++;
                $display("FAIL send_timeout ch%0d: got no accept within 5000 cycles", ch);
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_abort();
        abort     = 1'b1;
        cmd_valid = 1'b1;
        cmd_ch    = 1'($urandom_range(0, 1));
        #1;
        chk("ready_in_abort", int'(cmd_ch), int'(cmd_ready), 0);
        abort_edge = cyc + 1;
        @(negedge clk);
        abort     = 1'b0;
        cmd_valid = 1'b0;
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_da1", 0, int'(da1_data), MIDV);
        chk("rst_da2", 1, int'(da2_data), MIDV);
        chk("rst_busy", 0, int'(ch_busy), 0);
        chk("rst_qlevel", 0, int'(q_level), 0);
        idle(3);
        rst_n = 1'b1;
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int op;
        int sp;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_ch    = 1'b0;
        cmd_start = '0;
        cmd_step  = '0;
        cmd_len   = '0;
        cmd_div   = '0;
        abort     = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // Single ramp, saturation both ways, len==0, and two chained segments.
        send(0, 'h0000, 1, 4, 0);
        idle(8);
        send(1, 'h3FFE, 2, 3, 2);
        idle(12);
        send(0, 'h0001, -2, 3, 1);
        send(1, 'h1234, 5, 0, 1);
        idle(10);
        send(0, 'h0100, -1, 2, 0);
        send(0, 'h0200, 0, 2, 0);
        idle(8);

        // Backpressure: a long head segment, four more queued, ch1 still accepted, fifth ch0 waits.
        send(0, 'h0000, 1, 1000, 0);
        for (int i = 0; i < 4; i++) send(0, 'h0400 + i, 1, 2, 0);
        send(1, 'h0800, 3, 3, 0);
        send(0, 'h0500, 1, 2, 0);
        idle(20);

        // Abort while both channels run with queued work.
        send(0, 'h0010, 1, 20, 0);
        send(0, 'h0020, 1, 5, 0);
        send(1, 'h0030, 1, 20, 0);
        send(1, 'h0040, 1, 5, 0);
        idle(5);
        do_abort();
        idle(5);

        // Asynchronous reset between edges, then normal start latency.
        send(0, 'h0500, 3, 50, 1);
        idle(10);
        async_reset();
        send(0, 'h0777, 1, 3, 0);
        idle(6);

        for (int i = 0; i < 300; i++) begin
            op = int'($urandom_range(0, 39));
            if (op == 0) begin
                do_abort();
            end else if (op < 8) begin
                idle(int'($urandom_range(1, 5)));
            end else begin
                if ($urandom_range(0, 1) == 0) sp = int'($urandom_range(0, 8)) - 4;
                else sp = int'($urandom_range(0, MAXV)) - 'h2000;
                send(int'($urandom_range(0, 1)), int'($urandom_range(0, MAXV)), sp,
                     int'($urandom_range(0, 6)), int'($urandom_range(0, 3)));
            end
        end

        idle(200);
        chk("drain", 0, expq[0].size(), 0);
        chk("drain", 1, expq[1].size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
